// File: rtl/unified_mem.sv
// unified_mem: single-ported unified instruction/data memory with a fetch/data arbiter.
// Latency: one access granted per cycle, read data registered and valid the cycle after the grant.
// Backpressure: the losing requester sees ready low and stall high, and holds its request.
// Optional build macro UMEM_STARVE_GUARD_EN adds the fetch starvation guard for ARB_MODE 0.
module unified_mem #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        stall
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    // Storage is deliberately not reset; its initial image is loaded by the simulation environment.
    logic [31:0] mem [WORDS];

    logic [DEPTH_LOG2-1:0] if_idx;
    logic [DEPTH_LOG2-1:0] d_idx;
    logic [1:0]            d_lane;
    logic [7:0]            d_byte;
    logic                  d_misaligned;
    logic                  grant_if;
    logic                  grant_d;
    logic                  last_grant_if;   // 1 = fetch granted last, 0 = data (reset value)
    logic                  starve_fire;

    // Upper address bits wrap the address space; fetch lane bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:DEPTH_LOG2+2], if_addr[1:0], d_addr[31:DEPTH_LOG2+2]};

    assign if_idx       = if_addr[DEPTH_LOG2+1:2];
    assign d_idx        = d_addr[DEPTH_LOG2+1:2];
    assign d_lane       = d_addr[1:0];
    assign d_misaligned = !d_be && (d_lane != 2'd0);

`ifdef UMEM_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 2);
    logic [CW-1:0] starve_cnt;

    // Count consecutive cycles the fetch port waits; clear when it is served or stops asking.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (ARB_MODE == 0 && if_req && !grant_if) begin
            if (starve_cnt != CW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    assign starve_fire = (ARB_MODE == 0) && (starve_cnt == CW'(STARVE_MAX));
`else
    localparam bit unused_starve_cfg = (STARVE_MAX > 0);
    assign starve_fire = 1'b0;
`endif

    // Grant decision: a lone requester always wins; conflicts follow the arbitration mode.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (!reset) begin
            if (if_req && !d_req) begin
                grant_if = 1'b1;
            end else if (d_req && !if_req) begin
                grant_d = 1'b1;
            end else if (if_req && d_req) begin
                if (ARB_MODE == 1) begin
                    grant_if = !last_grant_if;
                    grant_d  = last_grant_if;
                end else begin
                    grant_if = starve_fire;
                    grant_d  = !starve_fire;
                end
            end
        end
    end

    assign if_ready = grant_if;
    assign d_ready  = grant_d;
    assign stall    = !reset && ((if_req && !if_ready) || (d_req && !d_ready));

    // Little-endian byte lane select for byte reads.
    always_comb begin
        d_byte = 8'h00;
        case (d_lane)
            2'd0: d_byte = mem[d_idx][7:0];
            2'd1: d_byte = mem[d_idx][15:8];
            2'd2: d_byte = mem[d_idx][23:16];
            2'd3: d_byte = mem[d_idx][31:24];
            default: d_byte = 8'h00;
        endcase
    end

    // Commit granted writes; misaligned word writes are dropped.
    always_ff @(posedge clk) begin
        if (grant_d && d_we && !d_misaligned) begin
            if (d_be)
                mem[d_idx][{d_lane, 3'b000} +: 8] <= d_wdata[7:0];
            else
                mem[d_idx] <= d_wdata;
        end
    end

    // Registered read data, error pulse and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata      <= '0;
            d_rdata       <= '0;
            d_err         <= 1'b0;
            last_grant_if <= 1'b0;
        end else begin
            d_err <= grant_d && d_misaligned;
            if (grant_if) begin
                if_rdata      <= mem[if_idx];
                last_grant_if <= 1'b1;
            end
            if (grant_d) begin
                last_grant_if <= 1'b0;
                if (!d_we) begin
                    if (d_misaligned)
                        d_rdata <= '0;
                    else if (d_be)
                        d_rdata <= {24'b0, d_byte};
                    else
                        d_rdata <= mem[d_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: directed checks of unified_mem access, arbitration and reset behaviour.
// Two instances: u0 with fixed-priority arbitration, u1 with round-robin arbitration.
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_unified_mem;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Instance u0 (ARB_MODE 0)
    logic        if_req, if_ready, d_req, d_we, d_be, d_ready, d_err, stall;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    // Instance u1 (ARB_MODE 1)
    logic        b_if_req, b_if_ready, b_d_req, b_d_we, b_d_be, b_d_ready, b_d_err, b_stall;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;

    always #5 clk = ~clk;

    unified_mem #(.DEPTH_LOG2(10), .ARB_MODE(0), .STARVE_MAX(4)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err), .stall(stall)
    );

    unified_mem #(.DEPTH_LOG2(10), .ARB_MODE(1), .STARVE_MAX(4)) u1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata), .d_err(b_d_err), .stall(b_stall)
    );

    task automatic set_d(input logic req, input logic we, input logic be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        d_req = req; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    endtask

    task automatic set_b_d(input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        b_d_req = req; b_d_we = we; b_d_be = 1'b0; b_d_addr = addr; b_d_wdata = wdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0;
        set_d(1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678);
        b_if_req = 1'b0; b_if_addr = 32'h0;
        set_b_d(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        if (if_ready !== 1'b0) begin $display("FAIL reset_if_ready: got %b want 0", if_ready); n_fail++; end
        n_checks++;
        if (d_ready !== 1'b0) begin $display("FAIL reset_d_ready: got %b want 0", d_ready); n_fail++; end
        n_checks++;
        if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); n_fail++; end
        n_checks++;
        if (if_rdata !== 32'h0) begin $display("FAIL reset_if_rdata: got %h want 0", if_rdata); n_fail++; end
        n_checks++;
        if (d_rdata !== 32'h0) begin $display("FAIL reset_d_rdata: got %h want 0", d_rdata); n_fail++; end
        n_checks++;
        if (d_err !== 1'b0) begin $display("FAIL reset_d_err: got %b want 0", d_err); n_fail++; end
        n_checks++;
        if (b_if_rdata !== 32'h0 || b_d_rdata !== 32'h0) begin
            $display("FAIL reset_u1_rdata: got %h/%h want 0/0", b_if_rdata, b_d_rdata); n_fail++;
        end
        n_checks++;
        @(negedge clk);
        reset = 1'b0; if_req = 1'b0;
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_word_rw();
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        #1;
        if (d_ready !== 1'b1) begin $display("FAIL wr_d_ready: got %b want 1", d_ready); n_fail++; end
        n_checks++;
        if (stall !== 1'b0) begin $display("FAIL wr_stall: got %b want 0", stall); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        if (d_ready !== 1'b1) begin $display("FAIL rd_d_ready: got %b want 1", d_ready); n_fail++; end
        n_checks++;
        if (d_rdata !== 32'h0) begin $display("FAIL rd_write_no_disturb: got %h want 0", d_rdata); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_rdata !== 32'hDEADBEEF) begin $display("FAIL word_read: got %h want deadbeef", d_rdata); n_fail++; end
        n_checks++;
    endtask

    task automatic test_byte_access();
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h40, 32'h11223344);
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b1, 32'h43, 32'hFFFFFFA5);
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b1, 32'h41, 32'h0);
        #1;
        if (d_rdata !== 32'hA5223344) begin $display("FAIL byte_merge: got %h want a5223344", d_rdata); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b1, 32'h43, 32'h0);
        #1;
        if (d_rdata !== 32'h00000033) begin $display("FAIL byte_read_41: got %h want 00000033", d_rdata); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_rdata !== 32'h000000A5) begin $display("FAIL byte_read_43: got %h want 000000a5", d_rdata); n_fail++; end
        n_checks++;
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h42, 32'hCAFEF00D);
        #1;
        if (d_ready !== 1'b1) begin $display("FAIL mis_wr_ready: got %b want 1", d_ready); n_fail++; end
        n_checks++;
        if (d_err !== 1'b0) begin $display("FAIL mis_err_early: got %b want 0", d_err); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_err !== 1'b1) begin $display("FAIL mis_err_pulse: got %b want 1", d_err); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        if (d_err !== 1'b0) begin $display("FAIL mis_err_width: got %b want 0", d_err); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h41, 32'h0);
        #1;
        if (d_rdata !== 32'hA5223344) begin $display("FAIL mis_no_write: got %h want a5223344", d_rdata); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_rdata !== 32'h0) begin $display("FAIL mis_read_zero: got %h want 0", d_rdata); n_fail++; end
        n_checks++;
        if (d_err !== 1'b1) begin $display("FAIL mis_rd_err: got %b want 1", d_err); n_fail++; end
        n_checks++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h8, 32'h0BADF00D);
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if_req = 1'b1; if_addr = (32'h1 << 12) + 32'hA;
        #1;
        if (if_ready !== 1'b1) begin $display("FAIL wrap_if_ready: got %b want 1", if_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        if_req = 1'b0;
        #1;
        if (if_rdata !== 32'h0BADF00D) begin $display("FAIL wrap_fetch: got %h want 0badf00d", if_rdata); n_fail++; end
        n_checks++;
        if (d_rdata !== 32'h0) begin $display("FAIL wrap_d_hold: got %h want 0", d_rdata); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h100, 32'hAAAA0001);
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h104, 32'hBBBB0002);
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        #1;
        if (d_rdata !== 32'hAAAA0001) begin $display("FAIL b2b_rd0: got %h want aaaa0001", d_rdata); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b1, 1'b1, 1'b0, 32'h104, 32'hCCCC0003);
        #1;
        if (d_rdata !== 32'hBBBB0002) begin $display("FAIL b2b_rd1: got %h want bbbb0002", d_rdata); n_fail++; end
        n_checks++;
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_rdata !== 32'hCCCC0003) begin $display("FAIL b2b_raw: got %h want cccc0003", d_rdata); n_fail++; end
        n_checks++;
    endtask

    task automatic test_arb_fixed();
        logic exp_if;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h8;
        set_d(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 12; i++) begin
            #1;
`ifdef UMEM_STARVE_GUARD_EN
            exp_if = ((i % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            if (if_ready !== exp_if) begin $display("FAIL arb0_if_ready[%0d]: got %b want %b", i, if_ready, exp_if); n_fail++; end
            n_checks++;
            if (d_ready !== !exp_if) begin $display("FAIL arb0_d_ready[%0d]: got %b want %b", i, d_ready, !exp_if); n_fail++; end
            n_checks++;
            if (stall !== 1'b1) begin $display("FAIL arb0_stall[%0d]: got %b want 1", i, stall); n_fail++; end
            n_checks++;
            @(negedge clk);
        end
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_rdata !== 32'hA5223344) begin $display("FAIL arb0_d_rdata: got %h want a5223344", d_rdata); n_fail++; end
        n_checks++;
    endtask

    task automatic test_arb_round_robin();
        logic [31:0] waddr [4];
        logic [31:0] wdata [4];
        logic        exp_if  [4];
        logic [31:0] exp_ifd [5];
        logic [31:0] exp_dd  [5];
        waddr = '{32'h10, 32'h14, 32'h20, 32'h24};
        wdata = '{32'h11111111, 32'h14141414, 32'h22222222, 32'h24242424};
        exp_if  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_ifd = '{32'h0, 32'h22222222, 32'h22222222, 32'h24242424, 32'h24242424};
        exp_dd  = '{32'h0, 32'h0, 32'h11111111, 32'h11111111, 32'h14141414};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_b_d(1'b1, 1'b1, waddr[i], wdata[i]);
        end
        @(negedge clk);
        b_if_req = 1'b1; b_if_addr = 32'h20;
        set_b_d(1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (b_if_ready !== exp_if[c]) begin $display("FAIL rr_if_ready[%0d]: got %b want %b", c, b_if_ready, exp_if[c]); n_fail++; end
            n_checks++;
            if (b_d_ready !== !exp_if[c]) begin $display("FAIL rr_d_ready[%0d]: got %b want %b", c, b_d_ready, !exp_if[c]); n_fail++; end
            n_checks++;
            if (b_stall !== 1'b1) begin $display("FAIL rr_stall[%0d]: got %b want 1", c, b_stall); n_fail++; end
            n_checks++;
            if (b_if_rdata !== exp_ifd[c]) begin $display("FAIL rr_if_rdata[%0d]: got %h want %h", c, b_if_rdata, exp_ifd[c]); n_fail++; end
            n_checks++;
            if (b_d_rdata !== exp_dd[c]) begin $display("FAIL rr_d_rdata[%0d]: got %h want %h", c, b_d_rdata, exp_dd[c]); n_fail++; end
            n_checks++;
            @(negedge clk);
            if (c == 0) b_if_addr = 32'h24;
            if (c == 1) b_d_addr  = 32'h14;
        end
        b_if_req = 1'b0;
        set_b_d(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (b_if_rdata !== exp_ifd[4]) begin $display("FAIL rr_if_final: got %h want %h", b_if_rdata, exp_ifd[4]); n_fail++; end
        n_checks++;
        if (b_d_rdata !== exp_dd[4]) begin $display("FAIL rr_d_final: got %h want %h", b_d_rdata, exp_dd[4]); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        set_d(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        set_d(1'b1, 1'b1, 1'b0, 32'h40, 32'h55555555);
        #1;
        if (d_ready !== 1'b0 || if_ready !== 1'b0) begin
            $display("FAIL mid_ready: got if=%b d=%b want 0/0", if_ready, d_ready); n_fail++;
        end
        n_checks++;
        if (stall !== 1'b0) begin $display("FAIL mid_stall: got %b want 0", stall); n_fail++; end
        n_checks++;
        @(negedge clk);
        #1;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            $display("FAIL mid_rdata_clear: got %h/%h want 0/0", if_rdata, d_rdata); n_fail++;
        end
        n_checks++;
        reset = 1'b0; if_req = 1'b0;
        set_d(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (d_rdata !== 32'hA5223344) begin $display("FAIL mid_no_commit: got %h want a5223344", d_rdata); n_fail++; end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_access();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_arb_fixed();
        test_arb_round_robin();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
